// File: rtl/fetch_inst_buffer_pkg.sv
// Shared definitions for the fetch instruction buffer: packet geometry,
// field offsets inside a packet, and small helpers. FetchStage2 and Decode
// import the same package so packet layout stays consistent.
package fetch_inst_buffer_pkg;

    localparam int SIZE_INSTRUCTION = 32;
    localparam int SIZE_PC          = 32;
    localparam int SIZE_CTI_LOG     = 4;

    localparam int FIB_SLOTS = 4;
    localparam int FIB_DEPTH = 16;
    localparam int FIB_PKT_W = SIZE_INSTRUCTION + 2 * SIZE_PC + SIZE_CTI_LOG + 1;

    // Packet layout, LSB first: prediction, ctiqTag, targetAddr, pc, instruction.
    localparam int FIB_PRED_LSB   = 0;
    localparam int FIB_CTIQ_LSB   = FIB_PRED_LSB + 1;
    localparam int FIB_TARGET_LSB = FIB_CTIQ_LSB + SIZE_CTI_LOG;
    localparam int FIB_PC_LSB     = FIB_TARGET_LSB + SIZE_PC;
    localparam int FIB_INST_LSB   = FIB_PC_LSB + SIZE_PC;

    typedef struct packed {
        logic [SIZE_INSTRUCTION-1:0] instruction;
        logic [SIZE_PC-1:0]          pc;
        logic [SIZE_PC-1:0]          targetAddr;
        logic [SIZE_CTI_LOG-1:0]     ctiqTag;
        logic                        prediction;
    } fibPacket_t;

    // Number of set bits in a 4-slot valid mask.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/fetch_inst_buffer_compact.sv
// fib_compact: left-justifies the valid slots of a 4-wide fetch bundle so the
// oldest valid packet lands in slot 0. Purely combinational. Handles any mask,
// not only the contiguous masks FetchStage2 normally produces.
module fib_compact
    import fetch_inst_buffer_pkg::*;
#(
    parameter int PKT_W = FIB_PKT_W
) (
    input  logic [3:0]            instValid,
    input  logic [3:0][PKT_W-1:0] instPacket,
    output logic [3:0][PKT_W-1:0] compactPacket,
    output logic [2:0]            wrCnt
);

    logic [2:0] slotIdx_s;

    // Walk slots in program order, placing each valid packet in the next free output slot.
    always_comb begin
        compactPacket = '0;
        slotIdx_s     = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (instValid[i]) begin
                compactPacket[slotIdx_s[1:0]] = instPacket[i];
                slotIdx_s = slotIdx_s + 3'd1;
            end else begin
                slotIdx_s = slotIdx_s;
            end
        end
    end

    assign wrCnt = popcount4(instValid);

endmodule

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: circular FIFO between FetchStage2 and Decode. Accepts up
// to four compacted packets per cycle, presents the four oldest to Decode.
// Optional macro FETCH_INST_BUFFER_STATS_EN adds full-stall and flush counters.
module fetch_inst_buffer
    import fetch_inst_buffer_pkg::*;
#(
    parameter int DEPTH = FIB_DEPTH,
    parameter int PKT_W = FIB_PKT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             recoverFlag_i,
    input  logic             fs2Ready_i,
    input  logic             inst0Valid_i,
    input  logic             inst1Valid_i,
    input  logic             inst2Valid_i,
    input  logic             inst3Valid_i,
    input  logic [PKT_W-1:0] inst0Packet_i,
    input  logic [PKT_W-1:0] inst1Packet_i,
    input  logic [PKT_W-1:0] inst2Packet_i,
    input  logic [PKT_W-1:0] inst3Packet_i,
    input  logic             stall_i,
    output logic             fibFull_o,
    output logic             dec0Valid_o,
    output logic             dec1Valid_o,
    output logic             dec2Valid_o,
    output logic             dec3Valid_o,
    output logic [PKT_W-1:0] dec0Packet_o,
    output logic [PKT_W-1:0] dec1Packet_o,
    output logic [PKT_W-1:0] dec2Packet_o,
    output logic [PKT_W-1:0] dec3Packet_o,
    output logic             fibEmpty_o
`ifdef FETCH_INST_BUFFER_STATS_EN
    ,
    output logic [31:0]      fullCycles_o,
    output logic [15:0]      flushCount_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_SLOTS  = CNT_W'(FIB_SLOTS);
    localparam logic [CNT_W-1:0] FULL_LIMIT = CNT_W'(DEPTH - FIB_SLOTS);

    logic [PKT_W-1:0]            storage_r [DEPTH];
    logic [PTR_W-1:0]            rdPtr_r;
    logic [PTR_W-1:0]            wrPtr_r;
    logic [CNT_W-1:0]            count_r;

    logic [3:0][PKT_W-1:0]       inPacket_s;
    logic [3:0][PKT_W-1:0]       compactPacket_s;
    logic [3:0][PKT_W-1:0]       decPacket_s;
    logic [3:0][PTR_W-1:0]       wrAddr_s;
    logic [3:0]                  inValid_s;
    logic [3:0]                  decValid_s;
    logic [2:0]                  compactCnt_s;
    logic [2:0]                  wrCnt_s;
    logic [2:0]                  outCnt_s;
    logic [2:0]                  rdCnt_s;
    logic                        clear_s;
    logic                        wrEn_s;
    logic                        fibFull_s;

    assign inValid_s  = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign inPacket_s = {inst3Packet_i, inst2Packet_i, inst1Packet_i, inst0Packet_i};

    fib_compact #(.PKT_W(PKT_W)) u_compact (
        .instValid     (inValid_s),
        .instPacket    (inPacket_s),
        .compactPacket (compactPacket_s),
        .wrCnt         (compactCnt_s)
    );

    // Full is taken from the registered count only so upstream stall has no input path.
    assign fibFull_s = (count_r > FULL_LIMIT);
    assign clear_s   = flush_i | recoverFlag_i;
    assign wrEn_s    = fs2Ready_i & ~fibFull_s;

    // Per-cycle write/read amounts and the storage addresses the bundle lands in.
    always_comb begin
        wrCnt_s = 3'd0;
        if (wrEn_s) begin
            wrCnt_s = compactCnt_s;
        end else begin
            wrCnt_s = 3'd0;
        end
        if (count_r >= CNT_SLOTS) begin
            outCnt_s = 3'd4;
        end else begin
            outCnt_s = count_r[2:0];
        end
        if (stall_i) begin
            rdCnt_s = 3'd0;
        end else begin
            rdCnt_s = outCnt_s;
        end
        for (int j = 0; j < 4; j++) begin
            wrAddr_s[j] = wrPtr_r + PTR_W'(j);
        end
    end

    // Pointer and occupancy update; a clear discards any concurrent read or write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr_r <= '0;
            wrPtr_r <= '0;
            count_r <= '0;
        end else if (clear_s) begin
            rdPtr_r <= '0;
            wrPtr_r <= '0;
            count_r <= '0;
        end else begin
            rdPtr_r <= rdPtr_r + PTR_W'(rdCnt_s);
            wrPtr_r <= wrPtr_r + PTR_W'(wrCnt_s);
            count_r <= count_r + CNT_W'(wrCnt_s) - CNT_W'(rdCnt_s);
        end
    end

    // Packet storage write; contents are not reset, occupancy tracks validity.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (reset && !clear_s && (3'(j) < wrCnt_s)) begin
                storage_r[wrAddr_s[j]] <= compactPacket_s[j];
            end
        end
    end

    // Present the four oldest entries, wrapping modulo DEPTH.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            decPacket_s[n] = storage_r[rdPtr_r + PTR_W'(n)];
            decValid_s[n]  = (3'(n) < outCnt_s);
        end
    end

    assign fibFull_o    = fibFull_s;
    assign fibEmpty_o   = (count_r == '0);
    assign dec0Valid_o  = decValid_s[0];
    assign dec1Valid_o  = decValid_s[1];
    assign dec2Valid_o  = decValid_s[2];
    assign dec3Valid_o  = decValid_s[3];
    assign dec0Packet_o = decPacket_s[0];
    assign dec1Packet_o = decPacket_s[1];
    assign dec2Packet_o = decPacket_s[2];
    assign dec3Packet_o = decPacket_s[3];

`ifdef FETCH_INST_BUFFER_STATS_EN
    logic [31:0] fullCycles_r;
    logic [15:0] flushCount_r;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fullCycles_r <= 32'd0;
            flushCount_r <= 16'd0;
        end else begin
            if (fibFull_s && fs2Ready_i && (fullCycles_r != 32'hFFFF_FFFF)) begin
                fullCycles_r <= fullCycles_r + 32'd1;
            end
            if (clear_s && (flushCount_r != 16'hFFFF)) begin
                flushCount_r <= flushCount_r + 16'd1;
            end
        end
    end

    assign fullCycles_o = fullCycles_r;
    assign flushCount_o = flushCount_r;
`endif

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Self-checking bench for fetch_inst_buffer: a queue-based reference model,
// a per-cycle compare process, directed scenarios with literal expectations,
// then randomized traffic.
module tb_fetch_inst_buffer;
    import fetch_inst_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int PKT_W = FIB_PKT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, recov, ready, stall;
    logic [3:0] vmask;
    logic [3:0][PKT_W-1:0] pin;
    logic [3:0][PKT_W-1:0] saveP;
    logic full, empty;
    logic dv0, dv1, dv2, dv3;
    logic [PKT_W-1:0] dp0, dp1, dp2, dp3;
    logic [3:0] dValid;
    logic [3:0][PKT_W-1:0] dPkt;
    assign dValid = {dv3, dv2, dv1, dv0};
    assign dPkt   = {dp3, dp2, dp1, dp0};

`ifdef FETCH_INST_BUFFER_STATS_EN
    logic [31:0] fullCycles;
    logic [15:0] flushCount;
    logic [31:0] mFullCyc;
    logic [15:0] mFlushCnt;
`endif

    fetch_inst_buffer #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .recoverFlag_i(recov),
        .fs2Ready_i(ready),
        .inst0Valid_i(vmask[0]), .inst1Valid_i(vmask[1]),
        .inst2Valid_i(vmask[2]), .inst3Valid_i(vmask[3]),
        .inst0Packet_i(pin[0]), .inst1Packet_i(pin[1]),
        .inst2Packet_i(pin[2]), .inst3Packet_i(pin[3]),
        .stall_i(stall), .fibFull_o(full),
        .dec0Valid_o(dv0), .dec1Valid_o(dv1), .dec2Valid_o(dv2), .dec3Valid_o(dv3),
        .dec0Packet_o(dp0), .dec1Packet_o(dp1), .dec2Packet_o(dp2), .dec3Packet_o(dp3),
        .fibEmpty_o(empty)
`ifdef FETCH_INST_BUFFER_STATS_EN
        , .fullCycles_o(fullCycles), .flushCount_o(flushCount)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [PKT_W-1:0] rpkt();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[PKT_W-1:0];
    endfunction

    // Reference model: the buffer is just an ordered queue of packets.
    logic [PKT_W-1:0] mq[$];

    always @(posedge clk) begin : model
        int sz;
        int n;
        sz = mq.size();
        n  = (sz < 4) ? sz : 4;
`ifdef FETCH_INST_BUFFER_STATS_EN
        if (!reset) begin
            mFullCyc  = 32'd0;
            mFlushCnt = 16'd0;
        end else begin
            if (sz > DEPTH - 4 && ready && mFullCyc != 32'hFFFF_FFFF) mFullCyc++;
            if ((flush || recov) && mFlushCnt != 16'hFFFF) mFlushCnt++;
        end
`endif
        if (!reset || flush || recov) begin
            mq.delete();
        end else begin
            if (!stall) repeat (n) void'(mq.pop_front());
            if (ready && !(sz > DEPTH - 4)) begin
                for (int i = 0; i < 4; i++) if (vmask[i]) mq.push_back(pin[i]);
            end
        end
    end

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin : compare
        int sz;
        sz = mq.size();
        if (checkOn) begin
            chk("fibEmpty", 128'(empty), 128'(sz == 0));
            chk("fibFull", 128'(full), 128'(sz > DEPTH - 4));
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("decValid%0d", n), 128'(dValid[n]), 128'(n < sz));
                if (n < sz) chk($sformatf("decPacket%0d", n), 128'(dPkt[n]), 128'(mq[n]));
            end
`ifdef FETCH_INST_BUFFER_STATS_EN
            chk("fullCycles", 128'(fullCycles), 128'(mFullCyc));
            chk("flushCount", 128'(flushCount), 128'(mFlushCnt));
`endif
        end
    end

    task automatic bundle(input logic [3:0] m, input logic st);
        ready = 1'b1;
        vmask = m;
        stall = st;
        for (int i = 0; i < 4; i++) pin[i] = rpkt();
        @(negedge clk);
        ready = 1'b0;
        vmask = 4'b0000;
    endtask

    initial begin
        logic [3:0] masks [5];
        masks = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        reset = 1'b0; flush = 1'b0; recov = 1'b0; ready = 1'b0; stall = 1'b1;
        vmask = 4'b0000; pin = '0; saveP = '0;
        repeat (2) @(negedge clk);
        checkOn = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset decValid", 128'(dValid), 128'(4'b0000));
        chk("reset empty", 128'(empty), 128'(1'b1));
        chk("reset full", 128'(full), 128'(1'b0));

        // Four-wide bundle held by stall, then drained in one read.
        bundle(4'b1111, 1'b1);
        chk("b4 valid", 128'(dValid), 128'(4'b1111));
        chk("b4 pkt0", 128'(dPkt[0]), 128'(pin[0]));
        chk("b4 pkt3", 128'(dPkt[3]), 128'(pin[3]));
        chk("b4 model size", 128'(mq.size()), 128'(4));
        stall = 1'b0;
        @(negedge clk);
        chk("b4 drained", 128'(empty), 128'(1'b1));

        // Partial bundles compact back to back.
        bundle(4'b0011, 1'b1);
        saveP = pin;
        bundle(4'b0111, 1'b1);
        chk("pq pkt0", 128'(dPkt[0]), 128'(saveP[0]));
        chk("pq pkt1", 128'(dPkt[1]), 128'(saveP[1]));
        chk("pq pkt2", 128'(dPkt[2]), 128'(pin[0]));
        chk("pq pkt3", 128'(dPkt[3]), 128'(pin[1]));
        chk("pq model size", 128'(mq.size()), 128'(5));
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        chk("pq tail valid", 128'(dValid), 128'(4'b0001));
        chk("pq tail pkt", 128'(dPkt[0]), 128'(pin[2]));
        stall = 1'b0;
        @(negedge clk);

        // Flush, offset pointers by 2, fill to 16, reject a 5th bundle.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bundle(4'b0011, 1'b1);
        stall = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bundle(4'b1111, 1'b1);
            chk($sformatf("fill%0d full", k), 128'(full), 128'(k == 3));
        end
        bundle(4'b1111, 1'b1);
        chk("reject model size", 128'(mq.size()), 128'(16));
        chk("reject full", 128'(full), 128'(1'b1));
        stall = 1'b0;
        @(negedge clk);
        chk("unstall full", 128'(full), 128'(1'b0));
        chk("unstall model size", 128'(mq.size()), 128'(12));
        repeat (2) @(negedge clk);
        chk("prewrap model size", 128'(mq.size()), 128'(4));

        // Read 4 from entries 14..1 while writing 3 at entries 2..4.
        bundle(4'b0111, 1'b0);
        stall = 1'b1;
        chk("wrap valid", 128'(dValid), 128'(4'b0111));
        chk("wrap pkt0", 128'(dPkt[0]), 128'(pin[0]));
        chk("wrap pkt2", 128'(dPkt[2]), 128'(pin[2]));

        // Recovery wins over a concurrent write.
        recov = 1'b1;
        bundle(4'b1111, 1'b0);
        recov = 1'b0;
        chk("recover empty", 128'(empty), 128'(1'b1));
        chk("recover valid", 128'(dValid), 128'(4'b0000));
`ifdef FETCH_INST_BUFFER_STATS_EN
        chk("flushCount literal", 128'(flushCount), 128'(16'd2));
`endif

        // Flush right after reset release, then a bundle is accepted normally.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("post-reset flush empty", 128'(empty), 128'(1'b1));
        bundle(4'b0001, 1'b1);
        chk("after flush valid", 128'(dValid), 128'(4'b0001));
        chk("after flush pkt", 128'(dPkt[0]), 128'(pin[0]));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 63) == 0);
            recov = ($urandom_range(0, 63) == 0);
            ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 1) == 0);
            vmask = masks[$urandom_range(0, 4)];
            for (int i = 0; i < 4; i++) pin[i] = rpkt();
            @(negedge clk);
        end
        flush = 1'b0; recov = 1'b0; ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_inst_buffer.md
# fetch_inst_buffer

Instruction buffer between FetchStage2 and Decode. It accepts up to four fetched instruction packets per cycle, in program order, under a per-slot valid mask. It compacts them into a circular FIFO and presents the four oldest entries to Decode each cycle. It decouples fetch bandwidth from decode stalls, and is emptied on branch recovery or flush.

## Interface
Parameters:
- DEPTH, 16: number of packet entries; power of two, at least 8.
- PKT_W, `SIZE_INSTRUCTION+2*`SIZE_PC+`SIZE_CTI_LOG+1: width of one instruction packet, {instruction, pc, targetAddr, ctiqTag, prediction}.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; buffer is cleared on the clk edge where reset==0.
- flush_i  in  1  synchronous clear of all entries; recovery or exception flush.
- recoverFlag_i  in  1  branch misprediction recovery; same effect as flush_i.
- fs2Ready_i  in  1  the bundle from FetchStage2 is present this cycle.
- instNValid_i  in  1  (N=0..3) slot N is valid; FetchStage2's filter vector.
- instNPacket_i  in  PKT_W  (N=0..3) packet for slot N.
- stall_i  in  1  Decode cannot accept this cycle.
- fibFull_o  out  1  fewer than 4 free entries; FetchStage1/2 must stall.
- decNValid_o  out  1  (N=0..3) output slot N holds a valid packet.
- decNPacket_o  out  PKT_W  (N=0..3) N-th oldest buffered packet.
- fibEmpty_o  out  1  occupancy is 0.

## Operation
- State: rdPtr and wrPtr (log2(DEPTH) bits each, wrap modulo DEPTH), count (log2(DEPTH)+1 bits), storage of DEPTH×PKT_W.
- Write enable: wrEn = fs2Ready_i & ~fibFull_o.
- Write count: wrCnt = popcount(instNValid_i) when wrEn, else 0.
- Write order: valid slots are compacted in ascending N order into storage[wrPtr], storage[wrPtr+1], and so on. Invalid slots leave no gap.
- Input guarantee: the valid mask is a contiguous run starting at slot 0, so the same compaction logic handles any mask.
- Read: outCnt = min(count,4). decNValid_o = (N < outCnt). decNPacket_o = storage[rdPtr+N] (modulo DEPTH). Packet contents are don't-care when the slot is invalid.
- Read count: rdCnt = outCnt when ~stall_i, else 0. Decode consumes all presented packets or none.
- Next state: count_next = count + wrCnt − rdCnt; wrPtr += wrCnt; rdPtr += rdCnt. Simultaneous read and write is legal in the same cycle.
- Clear priority: a reset edge, or a cycle with flush_i | recoverFlag_i, sets rdPtr = wrPtr = count = 0. Any write or read in that cycle is discarded; clear wins.
- fibFull_o = (count > DEPTH−4). It depends on registered count only; there is no combinational path from inputs to fibFull_o.
- fibEmpty_o = (count == 0).
- fs2Ready_i high while fibFull_o is high: the bundle is not written. Upstream is stalled by fibFull_o and re-presents the bundle.

## Timing
- Reset values: every decNValid_o = 0, fibEmpty_o = 1, fibFull_o = 0. Storage is not reset.
- Latency: a packet written at edge k appears on decNPacket_o in the cycle after edge k, at minimum 1 cycle. There is no same-cycle bypass.
- Output paths: outputs depend only on registered state; there is no combinational input→output path.
- Pointer wrap: a 4-packet read that spans entries DEPTH−2..1 is presented in order across the wrap.
- Flush or reset mid-stream: all outputs are invalid in the next cycle. A bundle presented in the cycle after the flush is accepted normally.

## Configuration
- FETCH_INST_BUFFER_STATS_EN: when defined, the block adds these outputs:
  - fullCycles_o (32b): increments on each cycle where fibFull_o & fs2Ready_i.
  - flushCount_o (16b): increments on each clear caused by flush_i | recoverFlag_i.
  - Both counters saturate, are cleared by reset only, and update on the edge of the counted event.
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared defines header: FIB_DEPTH, FIB_PKT_W, and the packet field offsets (instruction, pc, targetAddr, ctiqTag, prediction). FetchStage2 and Decode use the same definitions.
- Sub-module fib_compact:
  - Inputs: 4 valid bits and 4 packets.
  - Outputs: 4 left-justified packets and a 3-bit wrCnt.
  - Purely combinational.
- Top level contains the pointers, count, storage and read muxing.

## Test plan
- Reset (reset=0 for 2 cycles), then reset=1 → all decNValid_o=0, fibEmpty_o=1, fibFull_o=0.
- One bundle with mask 1111, stall_i=1 → next cycle decValid=1111, packets in slot order, count=4. Release stall → count=0 on the following edge.
- Mask 0011, then mask 0111, with stall_i=1 → count=5, dec0..3 = P0,P1,Q0,Q1. Unstall one cycle → dec0 = Q2 valid only, count=1.
- stall_i=1, keep writing 4 per cycle with DEPTH=16 → fibFull_o rises when count=16 (after the 4th write; count>12). A 5th bundle is not written and count stays 16. Unstall → count 12 and fibFull_o=0.
- Write and read in the same cycle across the pointer wrap (rdPtr=14, count=4, wrCnt=3, rdCnt=4) → count=3, rdPtr=2, order preserved.
- recoverFlag_i=1 with a concurrent write and fs2Ready_i → count=0 next cycle and nothing written. flush_i in the cycle after reset is released → empty. With the stats macro, flushCount_o increments by 1 per clear.
